// File: rtl/v_elem_streamer_if.sv
// Element output stream between v_elem_streamer and its consumer (scalar/store path).
interface v_elem_streamer_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 7
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;

  modport master (output out_valid, out_data, out_idx, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_idx, out_last, output out_ready);
endinterface

// File: rtl/v_elem_streamer.sv
// Read-side sequencer: walks the elements of a vector register group through the
// regfile element read port and presents each one on a valid/ready stream.
module v_elem_streamer #(
  parameter int V_REGS = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [4:0]        vs_addr_i,
  input  logic [IDX_W-1:0]  vl_i,
  input  logic [2:0]        sew_i,
  input  logic [2:0]        lmul_i,
  input  logic              sext_i,
  output logic [4:0]        el_rd_addr_o,
  output logic [4:0]        el_addr_o,
  input  logic [31:0]       el_data_in_i,
  v_elem_streamer_if.master out_if,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FIN} state_e;

  localparam logic [5:0] REGS_W = 6'(V_REGS);

  function automatic logic [7:0] epr_f(input logic [2:0] sew);
    case (sew)
      3'b001:  return 8'd8;
      3'b010:  return 8'd4;
      default: return 8'd16;
    endcase
  endfunction

  function automatic logic [7:0] nreg_f(input logic [2:0] lmul);
    case (lmul)
      3'b001:  return 8'd2;
      3'b010:  return 8'd4;
      default: return 8'd1;
    endcase
  endfunction

  function automatic logic [4:0] wrap_f(input logic [4:0] base, input logic [1:0] off);
    logic [5:0] sum;
    sum = {1'b0, base} + {4'b0, off};
    if (sum >= REGS_W) sum = sum - REGS_W;
    return sum[4:0];
  endfunction

  state_e            state_q;
  logic [4:0]        vs_addr_q;
  logic [IDX_W-1:0]  vl_q;
  logic [2:0]        sew_q;
  logic              sext_q;
  logic [4:0]        elem_q;
  logic [1:0]        reg_off_q;
  logic [4:0]        rd_addr_q;
  logic [IDX_W-1:0]  idx_q;
  logic              last_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic [7:0]        vlmax_d;
  logic              bad_vl_d;
  logic              empty_d;
  logic              elem_wrap_d;
  logic              last_next_d;
  logic              handshake_d;
  logic [DATA_W-1:0] ext_d;

  always_comb begin
    vlmax_d     = epr_f(sew_i) * nreg_f(lmul_i);
    bad_vl_d    = 32'(vl_i) > 32'(vlmax_d);
    empty_d     = (vl_i == '0);
    elem_wrap_d = ({3'b0, elem_q} == (epr_f(sew_q) - 8'd1));
    last_next_d = ((idx_q + 1'b1) == (vl_q - 1'b1));
    handshake_d = valid_q & out_if.out_ready;
  end

  // Only the low SEW bits of the regfile word belong to the element.
  always_comb begin
    ext_d = '0;
    case (sew_q)
      3'b001:  ext_d = sext_q ? DATA_W'($signed(el_data_in_i[15:0])) : DATA_W'(el_data_in_i[15:0]);
      3'b010:  ext_d = sext_q ? DATA_W'($signed(el_data_in_i))       : DATA_W'(el_data_in_i);
      default: ext_d = sext_q ? DATA_W'($signed(el_data_in_i[7:0]))  : DATA_W'(el_data_in_i[7:0]);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      vs_addr_q <= '0;
      vl_q      <= '0;
      sew_q     <= '0;
      sext_q    <= 1'b0;
      elem_q    <= '0;
      reg_off_q <= '0;
      rd_addr_q <= '0;
      idx_q     <= '0;
      last_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (start_i) begin
            vs_addr_q <= vs_addr_i;
            vl_q      <= vl_i;
            sew_q     <= sew_i;
            sext_q    <= sext_i;
            elem_q    <= '0;
            reg_off_q <= '0;
            idx_q     <= '0;
            if (empty_d || bad_vl_d) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
              err_q   <= bad_vl_d;
            end else begin
              state_q   <= S_STREAM;
              rd_addr_q <= vs_addr_i;
              last_q    <= (vl_i == IDX_W'(1));
              valid_q   <= 1'b1;
              busy_q    <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (handshake_d) begin
            if (last_q) begin
              state_q   <= S_FIN;
              valid_q   <= 1'b0;
              busy_q    <= 1'b0;
              last_q    <= 1'b0;
              done_q    <= 1'b1;
              err_q     <= 1'b0;
              idx_q     <= '0;
              elem_q    <= '0;
              reg_off_q <= '0;
              rd_addr_q <= '0;
            end else begin
              idx_q  <= idx_q + 1'b1;
              last_q <= last_next_d;
              if (elem_wrap_d) begin
                elem_q    <= '0;
                reg_off_q <= reg_off_q + 2'd1;
                rd_addr_q <= wrap_f(vs_addr_q, reg_off_q + 2'd1);
              end else begin
                elem_q <= elem_q + 5'd1;
              end
            end
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign el_rd_addr_o     = rd_addr_q;
  assign el_addr_o        = elem_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_idx   = idx_q;
  assign out_if.out_last  = last_q;
  assign out_if.out_data  = valid_q ? ext_d : '0;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_v_elem_streamer.sv
// Directed bench for v_elem_streamer with a behavioural regfile behind the read port.
module tb_v_elem_streamer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, sext;
  logic [4:0]  vs_addr, el_rd_addr, el_addr;
  logic [6:0]  vl;
  logic [2:0]  sew, lmul;
  logic [31:0] el_data;
  logic        busy, done, err;
  logic [31:0] rf [32][16];
  logic [4:0]  wrap_seq [4];
  int          n_chk = 0;
  int          n_fail = 0;

  v_elem_streamer_if #(.DATA_W(32), .IDX_W(7)) sif ();

  assign el_data = rf[el_rd_addr][el_addr[3:0]];

  v_elem_streamer #(.V_REGS(32), .DATA_W(32), .IDX_W(7)) dut (
    .clk(clk), .rst(rst), .start_i(start), .vs_addr_i(vs_addr), .vl_i(vl),
    .sew_i(sew), .lmul_i(lmul), .sext_i(sext), .el_rd_addr_o(el_rd_addr),
    .el_addr_o(el_addr), .el_data_in_i(el_data), .out_if(sif),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_elem(input string tag, input int idx, input logic last,
                          input logic [31:0] data, input logic [4:0] rd, input logic [4:0] el);
    chk({tag, " valid"}, 32'(sif.out_valid), 32'd1);
    chk({tag, " busy"},  32'(busy), 32'd1);
    chk({tag, " idx"},   32'(sif.out_idx), 32'(idx));
    chk({tag, " last"},  32'(sif.out_last), 32'(last));
    chk({tag, " data"},  sif.out_data, data);
    chk({tag, " rd"},    32'(el_rd_addr), 32'(rd));
    chk({tag, " el"},    32'(el_addr), 32'(el));
  endtask

  task automatic chk_fin(input string tag, input logic exp_err);
    chk({tag, " done"},  32'(done), 32'd1);
    chk({tag, " err"},   32'(err), 32'(exp_err));
    chk({tag, " busy"},  32'(busy), 32'd0);
    chk({tag, " valid"}, 32'(sif.out_valid), 32'd0);
  endtask

  task automatic go(input logic [4:0] a, input logic [6:0] n, input logic [2:0] s,
                    input logic [2:0] m, input logic x);
    vs_addr = a; vl = n; sew = s; lmul = m; sext = x; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < 32; r++)
      for (int e = 0; e < 16; e++)
        rf[r][e] = {8'(r), 8'(e), 16'hC3A5};
    rst = 1'b1; start = 1'b0; vs_addr = 5'd0; vl = 7'd0; sew = 3'd0; lmul = 3'd0;
    sext = 1'b0; sif.out_ready = 1'b0;
    tick(); tick();
    chk("rst valid", 32'(sif.out_valid), 32'd0);
    chk("rst data",  sif.out_data, 32'd0);
    chk("rst busy",  32'(busy), 32'd0);
    chk("rst done",  32'(done), 32'd0);
    chk("rst err",   32'(err), 32'd0);
    chk("rst rd",    32'(el_rd_addr), 32'd0);
    chk("rst idx",   32'(sif.out_idx), 32'd0);
    rst = 1'b0;
    tick();

    // sew32 lmul1 vl4; start held into STREAM with changed config must be ignored
    rf[3][0] = 32'd1; rf[3][1] = 32'd2; rf[3][2] = 32'd3; rf[3][3] = 32'd4;
    sif.out_ready = 1'b1;
    vs_addr = 5'd3; vl = 7'd4; sew = 3'b010; lmul = 3'b000; sext = 1'b0; start = 1'b1;
    tick();
    vs_addr = 5'd7; vl = 7'd1;
    chk_elem("t1 e0", 0, 1'b0, 32'd1, 5'd3, 5'd0);
    tick();
    start = 1'b0;
    chk_elem("t1 e1", 1, 1'b0, 32'd2, 5'd3, 5'd1);
    tick();
    chk_elem("t1 e2", 2, 1'b0, 32'd3, 5'd3, 5'd2);
    tick();
    chk_elem("t1 e3", 3, 1'b1, 32'd4, 5'd3, 5'd3);
    tick();
    chk_fin("t1 fin", 1'b0);
    tick();
    chk("t1 done clr", 32'(done), 32'd0);

    // sew8 lmul2 from reg 31: crosses into reg 0 after 16 elements
    for (int e = 0; e < 16; e++) begin
      rf[31][e] = 32'h5A5A5A00 + 32'(e);
      rf[0][e]  = 32'hFFFFFF80 + 32'(e);
    end
    go(5'd31, 7'd20, 3'b000, 3'b001, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk_elem("t2", i, (i == 19), (i < 16) ? 32'(i) : 32'h80 + 32'(i - 16),
               (i < 16) ? 5'd31 : 5'd0, 5'(i % 16));
      tick();
    end
    chk_fin("t2 fin", 1'b0);
    tick();

    // sew32 lmul4 from reg 30: regs 30,31,0,1
    wrap_seq[0] = 5'd30; wrap_seq[1] = 5'd31; wrap_seq[2] = 5'd0; wrap_seq[3] = 5'd1;
    for (int k = 0; k < 4; k++)
      for (int e = 0; e < 4; e++)
        rf[wrap_seq[k]][e] = 32'h1000 * 32'(k) + 32'(e);
    go(5'd30, 7'd16, 3'b010, 3'b010, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk_elem("t3", i, (i == 15), 32'h1000 * 32'(i / 4) + 32'(i % 4), wrap_seq[i / 4], 5'(i % 4));
      tick();
    end
    chk_fin("t3 fin", 1'b0);
    tick();

    // sign/zero extension, upper regfile bits ignored
    rf[5][0] = 32'h1234FFFE;
    go(5'd5, 7'd1, 3'b001, 3'b000, 1'b1);
    chk_elem("t4 sext16", 0, 1'b1, 32'hFFFFFFFE, 5'd5, 5'd0);
    tick(); chk_fin("t4a fin", 1'b0); tick();
    go(5'd5, 7'd1, 3'b001, 3'b000, 1'b0);
    chk_elem("t4 zext16", 0, 1'b1, 32'h0000FFFE, 5'd5, 5'd0);
    tick(); chk_fin("t4b fin", 1'b0); tick();
    rf[6][0] = 32'h7F7F7F81;
    go(5'd6, 7'd1, 3'b111, 3'b000, 1'b1);
    chk_elem("t4 sext8", 0, 1'b1, 32'hFFFFFF81, 5'd6, 5'd0);
    tick(); chk_fin("t4c fin", 1'b0); tick();

    // backpressure: ready 1,0,0,1,1
    rf[8][0] = 32'd10; rf[8][1] = 32'd11; rf[8][2] = 32'd12;
    sif.out_ready = 1'b1;
    go(5'd8, 7'd3, 3'b010, 3'b000, 1'b0);
    chk_elem("t5 c1", 0, 1'b0, 32'd10, 5'd8, 5'd0);
    tick();
    sif.out_ready = 1'b0;
    chk_elem("t5 c2", 1, 1'b0, 32'd11, 5'd8, 5'd1);
    tick();
    chk_elem("t5 c3", 1, 1'b0, 32'd11, 5'd8, 5'd1);
    tick();
    sif.out_ready = 1'b1;
    chk_elem("t5 c4", 1, 1'b0, 32'd11, 5'd8, 5'd1);
    tick();
    chk_elem("t5 c5", 2, 1'b1, 32'd12, 5'd8, 5'd2);
    tick();
    chk_fin("t5 fin", 1'b0);
    tick();

    // vl one above VLMAX, then vl zero
    go(5'd9, 7'd5, 3'b010, 3'b000, 1'b0);
    chk_fin("t6 over", 1'b1);
    tick();
    chk("t6 done clr", 32'(done), 32'd0);
    chk("t6 err clr",  32'(err), 32'd0);
    tick();
    go(5'd9, 7'd0, 3'b010, 3'b000, 1'b0);
    chk_fin("t6 empty", 1'b0);
    tick(); tick();

    // reset mid-stream, reset beating start, then a clean restart
    for (int e = 0; e < 8; e++) rf[2][e] = 32'hAAAA0000 + 32'(e);
    go(5'd2, 7'd8, 3'b001, 3'b000, 1'b0);
    tick(); tick();
    chk_elem("t7 pre", 2, 1'b0, 32'd2, 5'd2, 5'd2);
    rst = 1'b1;
    tick();
    chk("t7 rst busy",  32'(busy), 32'd0);
    chk("t7 rst valid", 32'(sif.out_valid), 32'd0);
    chk("t7 rst done",  32'(done), 32'd0);
    chk("t7 rst err",   32'(err), 32'd0);
    chk("t7 rst idx",   32'(sif.out_idx), 32'd0);
    start = 1'b1;
    tick();
    chk("t7 rst+start busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_elem("t7", i, (i == 7), 32'(i), 5'd2, 5'(i));
      tick();
    end
    chk_fin("t7 fin", 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/v_elem_streamer.md
Name: v_elem_streamer

Overview:
Read-side sequencer for the vector register file element read port. On a start command it walks every element of a vector register group (vs_addr, lmul, sew, vl). It drives the register file element read address (register index plus element index), crossing register boundaries at LMUL>1. Each element is presented on a valid/ready output stream for the scalar/store path. It pairs with the element write port the register file already accepts: this block is the reader of what the writer populated.

Parameters:
V_REGS, 32, number of vector registers; register index wraps modulo V_REGS.
DATA_W, 32, output element width; elements are zero- or sign-extended to this width.
IDX_W, 7, element index/count width; covers VLMAX = 64 (SEW=8, LMUL=4).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  command strobe; accepted only in IDLE
vs_addr  in  5  base register of source group
vl  in  IDX_W  number of elements to stream
sew  in  3  000=8b, 001=16b, 010=32b, others treated as 8b
lmul  in  3  000=1 reg, 001=2 regs, 010=4 regs, others treated as 1 reg
sext  in  1  1 = sign-extend element to DATA_W, 0 = zero-extend
el_rd_addr  out  5  register index to regfile element read port
el_addr  out  5  element index within register to regfile
el_data_in  in  32  combinational element data returned by regfile
out_valid  out  1  element available
out_ready  in  1  consumer accepts element
out_data  out  DATA_W  extended element
out_idx  out  IDX_W  element index within group (0..vl-1)
out_last  out  1  current element is index vl-1
busy  out  1  high in STREAM
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse with done when vl > VLMAX

Behaviour:
- Reset values: state IDLE; all outputs 0. Latched config registers are cleared to 0.
- EPR (elements per register) by SEW: 16, 8 or 4. NREG by LMUL: 1, 2 or 4. VLMAX = EPR*NREG.
- FSM states: IDLE, STREAM, FIN.
- IDLE, start=1:
  - Latch vs_addr, vl, sew, lmul and sext.
  - Clear elem counter, reg offset and out_idx.
  - If vl==0 or vl>VLMAX, go to FIN. err is set when vl>VLMAX.
  - Otherwise go to STREAM.
- start outside IDLE is ignored. Config input changes after acceptance have no effect.
- STREAM:
  - busy=1 and out_valid=1 every cycle.
  - el_rd_addr = (vs_addr_q + reg_off) mod 32; el_addr = elem counter.
  - out_data is the low SEW bits of el_data_in, extended per sext_q. Bits of el_data_in above SEW are ignored.
  - out_last = (out_idx == vl_q-1).
- Handshake:
  - Advance only on out_valid && out_ready.
  - While out_ready=0, el_rd_addr, el_addr, out_idx and out_last hold stable.
  - out_data follows el_data_in and is stable if the regfile is not written.
- Advance:
  - out_idx+1 and elem+1.
  - When elem==EPR-1, elem wraps to 0 and reg_off increments.
  - On handshake with out_last=1, go to FIN.
- FIN (one cycle): done=1, busy=0, out_valid=0, err as latched. Then go to IDLE. Earliest next start is accepted in the cycle after FIN.
- Latency: start at cycle T gives first out_valid at T+1. With out_ready held high, vl elements are delivered on T+1..T+vl and done pulses at T+vl+1.
- Register wrap: vs_addr=30, lmul=4 reads regs 30, 31, 0, 1.
- rst mid-STREAM: next cycle IDLE, outputs 0, no done/err pulse, partial transfer discarded.
- Simultaneous rst and start: rst wins.

Test Plan:
- sew=010, lmul=000, vs_addr=3, vl=4, reg3=0x00000004_00000003_00000002_00000001, out_ready=1 -> out_data 1,2,3,4 on T+1..T+4; out_last only at idx 3; done at T+5; busy T+1..T+4.
- sew=000, lmul=001, vs_addr=31, vl=20, out_ready=1 -> el_rd_addr 31 for idx 0..15, then 0 for idx 16..19 with el_addr 0..3; done at T+21.
- sew=001, sext=1, element 0xFFFE in reg5 el 0 -> out_data 0xFFFFFFFE. Same with sext=0 -> 0x0000FFFE.
- Backpressure: sew=010, vl=3, out_ready pattern 1,0,0,1,1 -> idx1 held with stable el_addr=1 across two stall cycles; three handshakes total; done one cycle after last handshake.
- Illegal/empty: sew=010, lmul=000, vl=5 -> no out_valid; done=1 and err=1 at T+1. vl=0 -> done=1, err=0 at T+1.
- rst asserted at idx 2 of a vl=8 stream -> next cycle busy=0, out_valid=0, done=0. A new start is then accepted normally and the stream restarts at idx 0.
